uc_stack: RTL

UC_STACK -- requirements
Module: uc_stack

---
 rtl/uc_pkg.sv | 13 +
 rtl/ret_stack.sv | 45 ++++
 rtl/uc_stack.sv | 124 ++++++++++++
 3 files changed

// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - opcode constants and RUN/HALT encoding for the stack-aware control unit
package uc_pkg;
  localparam logic [5:0] OP_LI   = 6'b100000;
  localparam logic [5:0] OP_JMP  = 6'b100001;
  localparam logic [5:0] OP_JZ   = 6'b100010;
  localparam logic [5:0] OP_JNZ  = 6'b100011;
  localparam logic [5:0] OP_CALL = 6'b100100;
  localparam logic [5:0] OP_RET  = 6'b100101;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;
endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address LIFO with combinational top-of-stack read
module ret_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] SP_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] SP_ONE = (AW+1)'(1);

  logic [AW:0]      sp_q, sp_d, sp_m1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (sp_q == SP_MAX);
  assign empty   = (sp_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty & ~do_push;
  assign sp_m1   = sp_q - SP_ONE;
  // Top reads straight from the array so a just-pushed entry is visible next cycle.
  assign top     = empty ? '0 : mem_q[sp_m1[AW-1:0]];

  always_comb begin
    sp_d = sp_q;
    if (do_push)     sp_d = sp_q + SP_ONE;
    else if (do_pop) sp_d = sp_m1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_q <= '0;
    else        sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[sp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uc_stack.sv
// rtl/uc_stack.sv - microcontroller control unit with call/return stack, sticky errors and HALT
module uc_stack
  import uc_pkg::*;
#(
  parameter int PC_WIDTH    = 10,
  parameter int STACK_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic                z,
  input  logic [PC_WIDTH-1:0] pc_plus1,
  output logic                s_inc,
  output logic                s_inm,
  output logic                we3,
  output logic                wez,
  output logic                s_pila,
  output logic [2:0]          op_alu,
  output logic                pc_en,
  output logic [PC_WIDTH-1:0] ret_addr,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                overflow,
  output logic                underflow,
  output logic                halted
);
  logic [0:0] state_q, state_d;
  logic       ovf_q, ovf_d, unf_q, unf_d;
  logic       push, pop;

  ret_stack #(.WIDTH(PC_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_plus1),
    .top   (ret_addr),
    .full  (stack_full),
    .empty (stack_empty)
  );

  always_comb begin
    s_inc   = 1'b0;
    s_inm   = 1'b0;
    we3     = 1'b0;
    wez     = 1'b0;
    s_pila  = 1'b0;
    op_alu  = 3'b000;
    pc_en   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    state_d = state_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (state_q == ST_RUN) begin
      if (!opcode[5]) begin
        op_alu = opcode[4:2];
        we3    = 1'b1;
        wez    = 1'b1;
        s_inc  = 1'b1;
        pc_en  = 1'b1;
      end else begin
        case (opcode)
          OP_LI: begin
            s_inm = 1'b1;
            we3   = 1'b1;
            s_inc = 1'b1;
            pc_en = 1'b1;
          end
          OP_JMP: pc_en = 1'b1;
          OP_JZ: begin
            s_inc = ~z;
            pc_en = 1'b1;
          end
          OP_JNZ: begin
            s_inc = z;
            pc_en = 1'b1;
          end
          // A call on a full stack falls through to the next instruction.
          OP_CALL: begin
            pc_en = 1'b1;
            if (stack_full) begin
              s_inc = 1'b1;
              ovf_d = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
          OP_RET: begin
            pc_en = 1'b1;
            if (stack_empty) begin
              s_inc = 1'b1;
              unf_d = 1'b1;
            end else begin
              s_pila = 1'b1;
              pop    = 1'b1;
            end
          end
          OP_HALT: state_d = ST_HALT;
          default: begin
            s_inc = 1'b1;
            pc_en = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign halted    = (state_q == ST_HALT);
endmodule
